// File: rtl/demux_1to2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1to2_stream
//  Description : Registered 1-to-2 valid/ready stream demultiplexer with a
//                one-entry holding register and delivered-beat counter per
//                output channel. i_bitS=0 steers to channel 1, 1 to channel 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1to2_stream #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_bit,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_bitS,
  output logic [WIDTH-1:0] o_bit1,
  output logic             o_valid1,
  input  logic             i_ready1,
  output logic [WIDTH-1:0] o_bit2,
  output logic             o_valid2,
  input  logic             i_ready2,
  output logic [CNT_W-1:0] o_cnt1,
  output logic [CNT_W-1:0] o_cnt2
);

  localparam int c_NUM_CH = 2;

  logic [c_NUM_CH-1:0] w_ch_ready;
  logic                w_sel_free;
  logic                w_in_hs;

  assign w_ch_ready = {i_ready2, i_ready1};

  // A channel can take a new beat when empty or when it drains this cycle,
  // which gives one beat per cycle through each holding register.
  assign w_sel_free = i_bitS ? (!g_ch[1].r_valid || i_ready2)
                             : (!g_ch[0].r_valid || i_ready1);
  assign o_ready    = w_sel_free;
  assign w_in_hs    = i_valid && w_sel_free;

  for (genvar g = 0; g < c_NUM_CH; g++) begin : g_ch
    localparam logic c_SEL = (g == 1);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fill;
    logic             w_drain;

    assign w_fill  = w_in_hs && (i_bitS == c_SEL);
    assign w_drain = r_valid && w_ch_ready[g];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_cnt   <= '0;
      end else begin
        // Fill wins over drain so a simultaneous replace keeps valid high.
        if (w_fill) begin
          r_valid <= 1'b1;
          r_data  <= i_bit;
        end else if (w_drain) begin
          r_valid <= 1'b0;
        end
        if (w_drain) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_bit1   = g_ch[0].r_data;
  assign o_valid1 = g_ch[0].r_valid;
  assign o_cnt1   = g_ch[0].r_cnt;
  assign o_bit2   = g_ch[1].r_data;
  assign o_valid2 = g_ch[1].r_valid;
  assign o_cnt2   = g_ch[1].r_cnt;

endmodule
`default_nettype wire
